// File: rtl/vedic_mul16_seq.sv
// ---------------------------------------------------------------------------
// vedic_mul16_seq
//   Sequential 16x16 unsigned multiplier. A single 8x8 Vedic multiplier
//   (i8bit_mul) is reused over four steps. Each step multiplies one pair of
//   operand bytes and adds the shifted 16-bit partial product into a 32-bit
//   accumulator.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous, active-high reset
//     in_valid   operand pair valid
//     in_ready   operands can be accepted (IDLE only)
//     a, b       16-bit unsigned operands
//     out_valid  product valid on p (DONE)
//     out_ready  sink accepts product
//     p          32-bit product, driven from the accumulator register
//     busy       operation in flight (MUL or DONE)
//
//   Parameter ZERO_SKIP: when non-zero, an operand pair with a zero operand
//   completes after a single cycle instead of four multiply steps.
// ---------------------------------------------------------------------------

// 2x2 Vedic (Urdhva-Tiryagbhyam) multiplier cell.
module vedic_mul2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross_carry;
  logic high_term;

  always_comb begin
    high_term   = a[1] & b[1];
    cross_carry = (a[1] & b[0]) & (a[0] & b[1]);
    p[0]        = a[0] & b[0];
    p[1]        = (a[1] & b[0]) ^ (a[0] & b[1]);
    p[2]        = high_term ^ cross_carry;
    p[3]        = high_term & cross_carry;
  end
endmodule

// 4x4 Vedic multiplier built from four 2x2 cells.
module vedic_mul4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;
  logic [7:0] cross_sum;

  vedic_mul2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_mul2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_mul2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_mul2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));

  // The outer terms concatenate without overlap; the two cross terms share
  // a weight of 2^2 and are summed before being folded in.
  always_comb begin
    cross_sum = {4'b0000, q1} + {4'b0000, q2};
    p         = {q3, q0} + (cross_sum << 2);
  end
endmodule

// 8x8 Vedic multiplier built from four 4x4 blocks.
module i8bit_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0]  q0, q1, q2, q3;
  logic [15:0] cross_sum;

  vedic_mul4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(q0));
  vedic_mul4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(q1));
  vedic_mul4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(q2));
  vedic_mul4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(q3));

  always_comb begin
    cross_sum = {8'h00, q1} + {8'h00, q2};
    p         = {q3, q0} + (cross_sum << 4);
  end
endmodule

module vedic_mul16_seq #(
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [1:0]  step, step_next;
  logic [15:0] ra, ra_next;
  logic [15:0] rb, rb_next;
  logic [31:0] acc, acc_next;

  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] pp;
  logic [31:0] pp_shifted;
  logic        zero_operand;

  // step[0] selects the high byte of ra, step[1] the high byte of rb, giving
  // the order lo*lo, hi*lo, lo*hi, hi*hi.
  always_comb begin
    mul_a = step[0] ? ra[15:8] : ra[7:0];
    mul_b = step[1] ? rb[15:8] : rb[7:0];
  end

  i8bit_mul u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (pp)
  );

  always_comb begin
    unique case (step)
      2'd0:    pp_shifted = {16'h0000, pp};
      2'd3:    pp_shifted = {pp, 16'h0000};
      default: pp_shifted = {8'h00, pp, 8'h00};
    endcase
  end

  assign zero_operand = (ra == '0) || (rb == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
      ra    <= ra_next;
      rb    <= rb_next;
      acc   <= acc_next;
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    ra_next    = ra;
    rb_next    = rb;
    acc_next   = acc;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          ra_next    = a;
          rb_next    = b;
          acc_next   = '0;
          step_next  = '0;
          state_next = MUL;
        end
      end

      MUL: begin
        // The zero test looks at the captured operands in the first MUL
        // cycle, so a skipped operation still completes one cycle after
        // acceptance and no input-to-state path goes through the comparator.
        if ((ZERO_SKIP != 0) && zero_operand) begin
          acc_next   = '0;
          step_next  = '0;
          state_next = DONE;
        end else begin
          acc_next  = acc + pp_shifted;
          step_next = step + 2'd1;
          if (step == 2'd3) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign p         = acc;

endmodule

// File: tb/tb_vedic_mul16_seq.sv
// ---------------------------------------------------------------------------
// tb_vedic_mul16_seq
//   Self-checking bench for vedic_mul16_seq. Two instances are built, one
//   with zero skipping enabled and one without; use_nz selects which one the
//   shared stimulus drives. Expected products come from plain a*b.
// ---------------------------------------------------------------------------
module tb_vedic_mul16_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_ready;
  logic        use_nz;

  logic        in_valid_zs, in_ready_zs, out_valid_zs, busy_zs;
  logic        in_valid_nz, in_ready_nz, out_valid_nz, busy_nz;
  logic [31:0] p_zs, p_nz;

  logic        o_in_ready, o_out_valid, o_busy;
  logic [31:0] o_p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign in_valid_zs = in_valid & ~use_nz;
  assign in_valid_nz = in_valid & use_nz;

  assign o_in_ready  = use_nz ? in_ready_nz  : in_ready_zs;
  assign o_out_valid = use_nz ? out_valid_nz : out_valid_zs;
  assign o_busy      = use_nz ? busy_nz      : busy_zs;
  assign o_p         = use_nz ? p_nz         : p_zs;

  vedic_mul16_seq #(.ZERO_SKIP(1)) dut_zs (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_zs),
    .in_ready  (in_ready_zs),
    .a         (a),
    .b         (b),
    .out_valid (out_valid_zs),
    .out_ready (out_ready),
    .p         (p_zs),
    .busy      (busy_zs)
  );

  vedic_mul16_seq #(.ZERO_SKIP(0)) dut_nz (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid_nz),
    .in_ready  (in_ready_nz),
    .a         (a),
    .b         (b),
    .out_valid (out_valid_nz),
    .out_ready (out_ready),
    .p         (p_nz),
    .busy      (busy_nz)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model_mul(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Called on the falling edge right after the accepting edge. Counts cycles
  // until out_valid, and how often in_ready was high / busy was low meanwhile.
  task automatic wait_result(output int lat, output int ir_hi, output int busy_lo);
    int n;
    n = 0; ir_hi = 0; busy_lo = 0;
    while (!o_out_valid && n < 20) begin
      if (o_in_ready) ir_hi++;
      if (!o_busy) busy_lo++;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (o_in_ready) ir_hi++;
    if (!o_busy) busy_lo++;
    lat = n;
  endtask

  task automatic do_op(input logic nz, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] want_p, input int want_lat, input string tag);
    int lat, ir_hi, busy_lo;
    use_nz = nz;
    @(negedge clk);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    check_eq({tag, "_ready"}, 32'(o_in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat, ir_hi, busy_lo);
    check_eq({tag, "_lat"}, 32'(lat), 32'(want_lat));
    check_eq({tag, "_p"}, o_p, want_p);
    check_eq({tag, "_ready_low"}, 32'(ir_hi), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_lo), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_idle_valid"}, 32'(o_out_valid), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(o_in_ready), 32'd1);
  endtask

  initial begin
    int lat, ir_hi, busy_lo;
    int nsent, nrecv, cyc, last_out, spacing_bad, stray;
    logic [31:0] expq[$];
    logic [31:0] held;
    logic [15:0] x, y;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; use_nz = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready_zs", 32'(in_ready_zs), 32'd1);
    check_eq("rst_valid_zs", 32'(out_valid_zs), 32'd0);
    check_eq("rst_busy_zs", 32'(busy_zs), 32'd0);
    check_eq("rst_p_zs", p_zs, 32'd0);
    check_eq("rst_ready_nz", 32'(in_ready_nz), 32'd1);
    check_eq("rst_p_nz", p_nz, 32'd0);
    rst = 1'b0;

    do_op(1'b0, 16'h1234, 16'h5678, 32'h0626_0060, 4, "basic");
    do_op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 4, "max");
    do_op(1'b0, 16'h00FF, 16'hFF00, 32'h00FE_0100, 4, "bytes");
    do_op(1'b0, 16'h0000, 16'hABCD, 32'h0000_0000, 1, "zskip_a");
    do_op(1'b0, 16'hABCD, 16'h0000, 32'h0000_0000, 1, "zskip_b");
    do_op(1'b1, 16'h0000, 16'hABCD, 32'h0000_0000, 4, "nozskip");
    do_op(1'b1, 16'h8001, 16'h7FFF, model_mul(16'h8001, 16'h7FFF), 4, "nz_mul");

    // Backpressure: result must hold while new operands are offered.
    use_nz = 1'b0;
    @(negedge clk);
    a = 16'hBEEF; b = 16'h1357; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 16'h1111; b = 16'h2222;
    wait_result(lat, ir_hi, busy_lo);
    check_eq("bp_lat", 32'(lat), 32'd4);
    held = o_p;
    check_eq("bp_p", held, model_mul(16'hBEEF, 16'h1357));
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_p !== held || !o_out_valid || o_in_ready) stray++;
    end
    check_eq("bp_hold", 32'(stray), 32'd0);
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_release_valid", 32'(o_out_valid), 32'd0);
    check_eq("bp_release_ready", 32'(o_in_ready), 32'd1);

    // Back-to-back random stream with in_valid and out_ready held high.
    use_nz = 1'b0;
    x = 16'($urandom_range(1, 65535));
    y = 16'($urandom_range(1, 65535));
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    nsent = 0; nrecv = 0; cyc = 0; last_out = 0; spacing_bad = 0;
    while (nrecv < 20 && cyc < 400) begin
      if (o_in_ready) begin
        if (nsent < 20) begin
          expq.push_back(model_mul(a, b));
          nsent++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        a = 16'($urandom_range(1, 65535));
        b = 16'($urandom_range(1, 65535));
      end
      if (o_out_valid) begin
        if (expq.size() > 0) check_eq("b2b_p", o_p, expq.pop_front());
        else check_eq("b2b_extra", 32'(o_out_valid), 32'd0);
        if (nrecv > 0 && (cyc - last_out) != 6) spacing_bad++;
        last_out = cyc;
        nrecv++;
        if (nrecv == 20) in_valid = 1'b0;
      end
      if (nrecv < 20) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("b2b_count", 32'(nrecv), 32'd20);
    check_eq("b2b_spacing", 32'(spacing_bad), 32'd0);
    @(posedge clk);
    @(negedge clk);

    // Reset during MUL step 2 aborts the operation silently.
    use_nz = 1'b0;
    a = 16'h1234; b = 16'h5678; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_ready", 32'(o_in_ready), 32'd1);
    check_eq("abort_busy", 32'(o_busy), 32'd0);
    check_eq("abort_valid", 32'(o_out_valid), 32'd0);
    check_eq("abort_p", o_p, 32'd0);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_out_valid) stray++;
    end
    check_eq("abort_no_pulse", 32'(stray), 32'd0);
    do_op(1'b0, 16'd3, 16'd5, 32'h0000_000F, 4, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
